// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the 8N1 UART receiver.
//   BIT_PERIOD : default clock cycles per serial bit (100 MHz / 115200 baud)
//   CNT_W      : width of the per-bit cycle counter
//   state_t    : receiver FSM state encoding
package uart_receiver_pkg;
  localparam int unsigned BIT_PERIOD = 868;
  localparam int unsigned CNT_W      = 14;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;
endpackage

// File: rtl/uart_receiver_if.sv
// Bus between the UART receiver and its host/core.
//   IN        : serial line (idle high), asynchronous to the clock
//   rd        : pop strobe from the core
//   clr_err   : clears the sticky overrun flag
//   data      : FIFO head byte, meaningful while valid
//   valid     : FIFO non-empty
//   frame_err : one-cycle pulse on a bad stop bit
//   overrun   : sticky, a byte was dropped on a full FIFO
// slave = receiver side, master = core/line side.
interface uart_receiver_if;
  logic       IN;
  logic       rd;
  logic       clr_err;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  modport slave  (input  IN, rd, clr_err, output data, valid, frame_err, overrun);
  modport master (output IN, rd, clr_err, input  data, valid, frame_err, overrun);
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO for received UART bytes.
//   CLK, RST    : clock, async active-low reset
//   push, wdata : write a byte
//   pop         : advance the head (ignored while empty)
//   rdata       : head byte (combinational)
//   valid       : non-empty
//   full        : DEPTH entries held
//   overrun_evt : push refused because full with no pop this cycle
// DEPTH must be a power of two, >= 2.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       valid,
  output logic       full,
  output logic       overrun_evt
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] P_ONE   = (AW+1)'(1);
  localparam logic [AW:0] P_DEPTH = (AW+1)'(DEPTH);

  logic [7:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] w_count;
  logic        w_pop, w_push;

  // Extra pointer bit distinguishes full from empty.
  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign valid       = (w_count != '0);
  assign full        = (w_count == P_DEPTH);
  assign rdata       = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop       = pop & valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push      = push & (~full | w_pop);
  assign overrun_evt = push & full & ~w_pop;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        r_wr_ptr <= r_wr_ptr + P_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + P_ONE;
    end
  end
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop line synchronizer, centre-sampling FSM,
// FWFT byte FIFO, framing-error pulse and sticky overrun flag.
//   CLK : system clock
//   RST : async active-low reset
//   bus : uart_receiver_if.slave (IN, rd, clr_err -> data, valid,
//         frame_err, overrun)
// T = clock cycles per bit (>= 4), DEPTH = FIFO entries (power of two).
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned T     = BIT_PERIOD,
  parameter int unsigned DEPTH = 4
) (
  input  logic           CLK,
  input  logic           RST,
  uart_receiver_if.slave bus
);
  localparam logic [CNT_W-1:0] P_HALF = CNT_W'(T/2 - 1);
  localparam logic [CNT_W-1:0] P_FULL = CNT_W'(T - 1);
  localparam logic [CNT_W-1:0] P_ONE  = CNT_W'(1);

  logic             r_sync1, r_in_s;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bitn;
  logic [7:0]       r_shift;
  logic             r_frame_err, r_overrun;

  logic w_half_hit, w_full_hit;
  logic w_cnt_clr, w_sample, w_push, w_frame_evt;
  logic [7:0] w_rdata;
  logic w_valid, w_full, w_overrun_evt;

  // Line synchronizer; resets to idle-high so reset never fakes a start bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= 1'b1;
      r_in_s  <= 1'b1;
    end else begin
      r_sync1 <= bus.IN;
      r_in_s  <= r_sync1;
    end
  end

  assign w_half_hit = (r_cnt == P_HALF);
  assign w_full_hit = (r_cnt == P_FULL);

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (!r_in_s) w_next = ST_START;
      ST_START: if (w_half_hit) w_next = r_in_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_full_hit && r_bitn == 3'd7) w_next = ST_STOP;
      ST_STOP:  if (w_full_hit) w_next = r_in_s ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (r_in_s) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_cnt_clr   = 1'b0;
    w_sample    = 1'b0;
    w_push      = 1'b0;
    w_frame_evt = 1'b0;
    unique case (r_state)
      ST_IDLE:  w_cnt_clr = 1'b1;
      // Re-centring: counting restarts at mid start bit, so every later
      // full-period hit lands mid-bit.
      ST_START: w_cnt_clr = w_half_hit;
      ST_DATA: begin
        w_sample  = w_full_hit;
        w_cnt_clr = w_full_hit;
      end
      ST_STOP: begin
        w_cnt_clr   = w_full_hit;
        w_push      = w_full_hit & r_in_s;
        w_frame_evt = w_full_hit & ~r_in_s;
      end
      ST_BREAK: w_cnt_clr = 1'b1;
      default:  w_cnt_clr = 1'b1;
    endcase
  end

  // Bit timing and data path
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt       <= '0;
      r_bitn      <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + P_ONE;
      if (r_state != ST_DATA) r_bitn <= '0;
      else if (w_sample)      r_bitn <= r_bitn + 3'd1;
      if (w_sample) r_shift[r_bitn] <= r_in_s;
      r_frame_err <= w_frame_evt;
      // Set beats clear when both land in the same cycle.
      if (w_overrun_evt)    r_overrun <= 1'b1;
      else if (bus.clr_err) r_overrun <= 1'b0;
    end
  end

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK         (CLK),
    .RST         (RST),
    .push        (w_push),
    .wdata       (r_shift),
    .pop         (bus.rd),
    .rdata       (w_rdata),
    .valid       (w_valid),
    .full        (w_full),
    .overrun_evt (w_overrun_evt)
  );

  // A drop can only ever be reported against a full FIFO.
  a_overrun_full: assert property (@(posedge CLK) disable iff (!RST)
    w_overrun_evt |-> w_full);

  assign bus.data      = w_rdata;
  assign bus.valid     = w_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;
  localparam int T   = 16;
  localparam int LAT = 2 + T/2 + 9*T + 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  uart_receiver_if bus();
  uart_receiver #(.T(T), .DEPTH(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int checks = 0, errors = 0;
  int cyc = 0, fe_cnt = 0, rise_cyc = -1, fall_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: scores every pop against the expected queue, counts frame_err
  // pulses and timestamps valid rising.
  always @(negedge CLK) begin
    if (!RST) begin
      exp_q.delete();
      prev_valid = 1'b0;
    end else begin
      if (bus.frame_err === 1'b1) fe_cnt++;
      if (bus.valid === 1'b1 && !prev_valid) rise_cyc = cyc;
      prev_valid = (bus.valid === 1'b1);
      if (bus.rd === 1'b1 && bus.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pop actual=%0h required=none", bus.data);
        end else chk("pop_data", {24'd0, bus.data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra);
    bus.IN = 1'b0; step(T);
    for (int i = 0; i < 8; i++) begin bus.IN = b[i]; step(T); end
    bus.IN = stop; step(T + extra);
    bus.IN = 1'b1;
  endtask

  task automatic read_byte(input string name);
    int w = 0;
    while (bus.valid !== 1'b1 && w < 4*T) begin step(1); w++; end
    if (bus.valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=valid0 required=valid1", name);
    end else begin
      bus.rd = 1'b1; step(1); bus.rd = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int fe0;
    bus.IN = 1'b1; bus.rd = 1'b0; bus.clr_err = 1'b0;
    #3 RST = 1'b0;
    #2;
    chk("rst_valid",     {31'd0, bus.valid},     32'd0);
    chk("rst_data",      {24'd0, bus.data},      32'd0);
    chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    chk("rst_overrun",   {31'd0, bus.overrun},   32'd0);
    step(3); RST = 1'b1; step(4);

    // Single frame, latency and pop
    exp_q.push_back(8'hA5);
    rise_cyc = -1; fall_cyc = cyc;
    send_frame(8'hA5, 1'b1, 0);
    chk("a5_latency", rise_cyc - fall_cyc, LAT);
    chk("a5_frame_err", fe_cnt, 0);
    read_byte("a5");
    chk("a5_valid_after_pop", {31'd0, bus.valid}, 32'd0);

    // Start-bit glitch
    rise_cyc = -1;
    bus.IN = 1'b0; step(4); bus.IN = 1'b1; step(3*T);
    chk("glitch_no_valid", rise_cyc, -1);
    chk("glitch_no_frame_err", fe_cnt, 0);

    // Bad stop bit, line held low, then recovery
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 2*T);
    chk("break_one_pulse", fe_cnt - fe0, 1);
    chk("break_valid", {31'd0, bus.valid}, 32'd0);
    step(2*T);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 0);
    read_byte("b81");
    chk("break_no_more_pulses", fe_cnt - fe0, 1);

    // Overrun: five frames, no reads
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1, 0);
      if (b == 4) chk("ovr_not_yet", {31'd0, bus.overrun}, 32'd0);
    end
    chk("ovr_set", {31'd0, bus.overrun}, 32'd1);
    for (int i = 0; i < 4; i++) read_byte("ovr_rd");
    chk("ovr_drained", {31'd0, bus.valid}, 32'd0);
    chk("ovr_sticky", {31'd0, bus.overrun}, 32'd1);
    bus.clr_err = 1'b1; step(1); bus.clr_err = 1'b0;
    chk("ovr_cleared", {31'd0, bus.overrun}, 32'd0);

    // Full FIFO with a pop in the push cycle
    for (int b = 1; b <= 4; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1, 0);
    end
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1, 0);
      begin step(LAT - 1); bus.rd = 1'b1; step(1); bus.rd = 1'b0; end
    join
    chk("full_pop_no_ovr", {31'd0, bus.overrun}, 32'd0);
    for (int i = 0; i < 4; i++) read_byte("full_rd");
    chk("full_drained", {31'd0, bus.valid}, 32'd0);

    // Reset mid-frame with a byte pending
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1, 0);
    chk("pre_rst_valid", {31'd0, bus.valid}, 32'd1);
    fork
      send_frame(8'hFF, 1'b1, 0);
      begin
        step(5*T + T/2);
        RST = 1'b0; #2;
        chk("mid_rst_valid",     {31'd0, bus.valid},     32'd0);
        chk("mid_rst_data",      {24'd0, bus.data},      32'd0);
        chk("mid_rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        chk("mid_rst_overrun",   {31'd0, bus.overrun},   32'd0);
        step(2); RST = 1'b1;
      end
    join
    step(T);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 0);
    read_byte("b5a");
    chk("post_rst_drained", {31'd0, bus.valid}, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
